competition_hazard: RTL and testbench

// - Glitch-free "enable AND data" status flag. Replaces a combinational en & din_rvs

---
 rtl/competition_hazard_pkg.sv | 7 +
 rtl/competition_hazard_sync_bit.sv | 25 ++
 rtl/competition_hazard.sv | 72 +++++++
 tb/tb_competition_hazard.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/competition_hazard_pkg.sv
// Shared defaults for the glitch-free enable/data status flag.
package competition_hazard_pkg;

  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_FILTER_CYCLES = 1;

endpackage

// File: rtl/competition_hazard_sync_bit.sv
// Single-bit shift-chain synchronizer for an input that may be asynchronous to clk.
module sync_bit
  import competition_hazard_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/competition_hazard.sv
// Registered, filtered replacement for a racy combinational (en & din_rvs) term.
// Note: rstn is an active-high synchronous reset despite its name.
module competition_hazard
  import competition_hazard_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic din_rvs,
  output logic flag
);

  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic          w_enS;
  logic          w_dinS;
  logic          w_cond;
  logic [CW-1:0] r_cnt;
  logic          r_flag;

  generate
    if (SYNC_STAGES < 2) begin : g_badSync
      $error("competition_hazard: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_badFilter
      $error("competition_hazard: FILTER_CYCLES must be >= 1");
    end
  endgenerate

  sync_bit #(.STAGES(SYNC_STAGES)) u_syncEn (
    .clk (clk),
    .rstn(rstn),
    .d   (en),
    .q   (w_enS)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_syncDin (
    .clk (clk),
    .rstn(rstn),
    .d   (din_rvs),
    .q   (w_dinS)
  );

  // Built only from synchronizer outputs so no input port reaches flag combinationally.
  assign w_cond = w_enS & w_dinS;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_cnt <= '0;
    end else if (!w_cond) begin
      r_cnt <= '0;
    end else if (r_cnt < CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Rises once cond has held FILTER_CYCLES cycles; falls immediately when cond drops.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_flag <= 1'b0;
    end else begin
      r_flag <= w_cond & (r_flag | (r_cnt == CNT_MAX));
    end
  end

  assign flag = r_flag;

endmodule

// File: tb/tb_competition_hazard.sv
// Randomized and directed bench for competition_hazard, run at FILTER_CYCLES 1 and 2.
module tb_competition_hazard;

  localparam int SYNC = 2;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic dinRvs;
  logic flag1;
  logic flag2;

  int nChecks = 0;
  int nPass   = 0;

  competition_hazard #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(1)) u_dut1 (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .din_rvs(dinRvs),
    .flag   (flag1)
  );

  competition_hazard #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(2)) u_dut2 (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .din_rvs(dinRvs),
    .flag   (flag2)
  );

  always #5 clk = ~clk;

  // Reference: per-edge input history; flag is set when the sampled AND has held
  // at least FILTER_CYCLES consecutive cycles, with any reset wiping the history.
  logic hEn  [MAXE];
  logic hDin [MAXE];
  int   lastRst    = -1000;
  int   edgeN      = 0;
  int   run        = 0;
  logic mFlag1     = 1'b0;
  logic mFlag2     = 1'b0;
  bit   modelValid = 1'b0;

  function automatic logic condAt(int j);
    int s;
    s = j - SYNC + 1;
    if (s < 0 || lastRst >= s) return 1'b0;
    return hEn[s] & hDin[s];
  endfunction

  initial forever begin
    logic c;
    @(posedge clk);
    c = condAt(edgeN - 1);
    run = c ? run + 1 : 0;
    hEn[edgeN]  = en;
    hDin[edgeN] = dinRvs;
    if (rstn === 1'b1) begin
      lastRst    = edgeN;
      run        = 0;
      mFlag1     = 1'b0;
      mFlag2     = 1'b0;
      modelValid = 1'b1;
    end else begin
      mFlag1 = (run >= 1);
      mFlag2 = (run >= 2);
    end
    edgeN++;
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Every cycle after the first reset the outputs must match the reference.
  initial forever begin
    @(negedge clk);
    if (modelValid) begin
      checkOutput("model_f1", flag1, mFlag1);
      checkOutput("model_f2", flag2, mFlag2);
    end
  end

  int flagEvents = 0;
  initial forever begin
    @(flag1 or flag2);
    flagEvents++;
  end

  task automatic applyStimulus(input logic e, input logic d, input logic r);
    en     = e;
    dinRvs = d;
    rstn   = r;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulseTest(input int n);
    int hi1;
    int hi2;
    hi1 = 0;
    hi2 = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (n) begin
      tick();
      if (flag1 === 1'b1) hi1++;
      if (flag2 === 1'b1) hi2++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (6) begin
      tick();
      if (flag1 === 1'b1) hi1++;
      if (flag2 === 1'b1) hi2++;
    end
    checkVal($sformatf("pulse%0d_f1_cycles", n), hi1, n);
    checkVal($sformatf("pulse%0d_f2_cycles", n), hi2, (n > 1) ? n - 1 : 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $display("%0d/%0d checks passed", nPass, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int evSnap;

    // Reset held for three edges with both inputs high.
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) begin
      tick();
      checkOutput("rst_flag_f1", flag1, 1'b0);
      checkOutput("rst_flag_f2", flag2, 1'b0);
    end
    checkVal("rst_cnt", 32'(u_dut1.r_cnt), 32'd0);
    checkVal("rst_syncEn", 32'(u_dut1.u_syncEn.r_chain), 32'd0);
    checkVal("rst_syncDin", 32'(u_dut1.u_syncDin.r_chain), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (4) tick();

    // Steady assert: F=1 rises after edge k+2, F=2 after edge k+3.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(); checkOutput("rise_k0_f1", flag1, 1'b0); checkOutput("rise_k0_f2", flag2, 1'b0);
    tick(); checkOutput("rise_k1_f1", flag1, 1'b0); checkOutput("rise_k1_f2", flag2, 1'b0);
    tick(); checkOutput("rise_k2_f1", flag1, 1'b1); checkOutput("rise_k2_f2", flag2, 1'b0);
    tick(); checkOutput("rise_k3_f1", flag1, 1'b1); checkOutput("rise_k3_f2", flag2, 1'b1);
    repeat (2) tick();
    checkOutput("hold_f1", flag1, 1'b1);

    // Deassert via din_rvs, then via en: flag falls after edge k+2.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(); checkOutput("fallD_k0_f1", flag1, 1'b1);
    tick(); checkOutput("fallD_k1_f1", flag1, 1'b1); checkOutput("fallD_k1_f2", flag2, 1'b1);
    tick(); checkOutput("fallD_k2_f1", flag1, 1'b0); checkOutput("fallD_k2_f2", flag2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    checkOutput("reraise_f1", flag1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(); checkOutput("fallE_k0_f1", flag1, 1'b1);
    tick(); checkOutput("fallE_k1_f1", flag1, 1'b1);
    tick(); checkOutput("fallE_k2_f1", flag1, 1'b0);

    // Near-coincident opposite edges mid-period must never produce a flag edge.
    repeat (4) tick();
    evSnap = flagEvents;
    @(posedge clk);
    #3 en = 1'b1;
    #1 dinRvs = 1'b0;
    repeat (8) begin
      tick();
      checkOutput("hazard_f1", flag1, 1'b0);
      checkOutput("hazard_f2", flag2, 1'b0);
    end
    checkVal("hazard_events", 32'(flagEvents - evSnap), 32'd0);

    // Short cond pulses against the filter.
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    pulseTest(1);
    pulseTest(2);
    pulseTest(5);

    // Mid-run reset with inputs held high.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("pre_rst_f1", flag1, 1'b1);
    checkOutput("pre_rst_f2", flag2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(); checkOutput("midrst_f1", flag1, 1'b0); checkOutput("midrst_f2", flag2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(); checkOutput("rel_r1_f1", flag1, 1'b0);
    tick(); checkOutput("rel_r2_f1", flag1, 1'b0);
    tick(); checkOutput("rel_r3_f1", flag1, 1'b1); checkOutput("rel_r3_f2", flag2, 1'b0);
    tick(); checkOutput("rel_r4_f2", flag2, 1'b1);

    // Randomized phase: inputs mostly stable with occasional toggles and resets.
    repeat (1500) begin
      tick();
      applyStimulus(($urandom_range(0, 5) == 0) ? ~en : en,
                    ($urandom_range(0, 5) == 0) ? ~dinRvs : dinRvs,
                    ($urandom_range(0, 99) == 0));
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
